err_stat_accum: RTL and testbench

ERR_STAT_ACCUM -- requirements
Module: err_stat_accum

---
 rtl/err_stat_pkg.sv | 15 +
 rtl/err_diff_stage.sv | 43 ++++
 rtl/err_stat_accum.sv | 143 ++++++++++++++
 tb/tb_err_stat_accum.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/err_stat_pkg.sv
// Shared types and default widths for the error-statistics accumulator.
package err_stat_pkg;

  localparam int unsigned DefWProd    = 16;
  localparam int unsigned DefNSamples = 65536;
  localparam int unsigned DefAccW     = 40;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/err_diff_stage.sv
// Stage 1: registers the signed error (approx - exact), its magnitude and the
// exact product, one bit wider than the products so the subtraction cannot wrap.
module err_diff_stage #(
  parameter int unsigned W_PROD = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     smp_valid,
  input  logic signed [W_PROD-1:0] exact,
  input  logic signed [W_PROD-1:0] approx,
  output logic                     s1_valid,
  output logic signed [W_PROD:0]   s1_diff,
  output logic        [W_PROD:0]   s1_abs,
  output logic signed [W_PROD-1:0] s1_exact
);

  logic signed [W_PROD:0] diff_d;
  logic        [W_PROD:0] abs_d;

  // Sign-extend both operands by one bit before subtracting.
  always_comb begin
    diff_d = $signed({approx[W_PROD-1], approx}) - $signed({exact[W_PROD-1], exact});
    abs_d  = diff_d[W_PROD] ? $unsigned(-diff_d) : $unsigned(diff_d);
  end

  // Pipeline register; the valid bit follows every accepted sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_diff  <= '0;
      s1_abs   <= '0;
      s1_exact <= '0;
    end else begin
      s1_valid <= smp_valid;
      if (smp_valid) begin
        s1_diff  <= diff_d;
        s1_abs   <= abs_d;
        s1_exact <= exact;
      end
    end
  end

endmodule

// File: rtl/err_stat_accum.sv
// Collects error statistics of an approximate multiplier against an exact one
// over a fixed-length run: signed/absolute error sums, maxima and counters.
module err_stat_accum
  import err_stat_pkg::*;
#(
  parameter int unsigned W_PROD    = DefWProd,
  parameter int unsigned N_SAMPLES = DefNSamples,
  parameter int unsigned ACC_W     = DefAccW
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic signed [W_PROD-1:0] i_exact,
  input  logic signed [W_PROD-1:0] i_approx,
  output logic signed [ACC_W-1:0]  o_sum_err,
  output logic        [ACC_W-1:0]  o_sum_abs_err,
  output logic signed [W_PROD-1:0] o_max_exact,
  output logic        [W_PROD:0]   o_max_abs_err,
  output logic        [31:0]       o_err_cnt,
  output logic        [31:0]       o_smp_cnt,
  output logic                     o_done
);

  localparam int unsigned CntW = $clog2(N_SAMPLES);

  // Worst case |diff| * N_SAMPLES must fit, so the sums can never wrap.
  if (ACC_W < W_PROD + 1 + CntW) begin : g_acc_w_check
    $error("err_stat_accum: ACC_W too narrow for W_PROD and N_SAMPLES");
  end

  state_e state_q, state_d;
  logic   drain_q, drain_d;
  logic   clr;
  logic   accept;
  logic   last;

  logic                     s1_valid;
  logic signed [W_PROD:0]   s1_diff;
  logic        [W_PROD:0]   s1_abs;
  logic signed [W_PROD-1:0] s1_exact;

  logic signed [ACC_W-1:0]  sum_err_q;
  logic        [ACC_W-1:0]  sum_abs_q;
  logic signed [W_PROD-1:0] max_exact_q;
  logic        [W_PROD:0]   max_abs_q;
  logic        [31:0]       err_cnt_q;
  logic        [31:0]       smp_cnt_q;

  assign o_ready = (state_q == StRun);
  assign o_done  = (state_q == StDone);
  assign accept  = i_valid && o_ready;
  assign last    = (smp_cnt_q == 32'(N_SAMPLES - 1));

  err_diff_stage #(
    .W_PROD(W_PROD)
  ) u_diff (
    .clk      (i_clk),
    .rst      (i_rst),
    .smp_valid(accept),
    .exact    (i_exact),
    .approx   (i_approx),
    .s1_valid (s1_valid),
    .s1_diff  (s1_diff),
    .s1_abs   (s1_abs),
    .s1_exact (s1_exact)
  );

  // Next-state logic; DRAIN spans two cycles so the last sample clears both stages.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    clr     = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (i_start) begin
          state_d = StRun;
          clr     = 1'b1;
        end
      end
      StRun: begin
        if (accept && last) begin
          state_d = StDrain;
          drain_d = 1'b0;
        end
      end
      StDrain: begin
        drain_d = 1'b1;
        if (drain_q) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Stage 2: fold each stage-1 result into the statistics; a start clears them.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sum_err_q   <= '0;
      sum_abs_q   <= '0;
      max_exact_q <= '0;
      max_abs_q   <= '0;
      err_cnt_q   <= '0;
      smp_cnt_q   <= '0;
    end else if (clr) begin
      sum_err_q   <= '0;
      sum_abs_q   <= '0;
      max_exact_q <= '0;
      max_abs_q   <= '0;
      err_cnt_q   <= '0;
      smp_cnt_q   <= '0;
    end else begin
      if (accept) smp_cnt_q <= smp_cnt_q + 32'd1;
      if (s1_valid) begin
        sum_err_q <= sum_err_q + ACC_W'(s1_diff);
        sum_abs_q <= sum_abs_q + ACC_W'(s1_abs);
        // max_exact starts at 0, so negative products never raise it.
        if (s1_exact > max_exact_q) max_exact_q <= s1_exact;
        if (s1_abs > max_abs_q) max_abs_q <= s1_abs;
        if (s1_diff != '0) err_cnt_q <= err_cnt_q + 32'd1;
      end
    end
  end

  assign o_sum_err     = sum_err_q;
  assign o_sum_abs_err = sum_abs_q;
  assign o_max_exact   = max_exact_q;
  assign o_max_abs_err = max_abs_q;
  assign o_err_cnt     = err_cnt_q;
  assign o_smp_cnt     = smp_cnt_q;

endmodule

// File: tb/tb_err_stat_accum.sv
// Directed bench for err_stat_accum: a short-run instance for the small
// scenarios and a full-length instance for the 256x256 operand sweep.
module tb_err_stat_accum;
  import err_stat_pkg::*;

  typedef struct {
    longint sum_err;
    longint sum_abs;
    longint max_exact;
    longint max_abs;
    longint err_cnt;
    longint smp_cnt;
  } stats_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Short-run instance
  logic               rst_a, start_a, valid_a, ready_a, done_a;
  logic signed [15:0] exact_a, approx_a, max_exact_a;
  logic signed [39:0] sum_err_a;
  logic        [39:0] sum_abs_a;
  logic        [16:0] max_abs_a;
  logic        [31:0] err_cnt_a, smp_cnt_a;

  // Full-length instance
  logic               rst_b, start_b, valid_b, ready_b, done_b;
  logic signed [15:0] exact_b, approx_b, max_exact_b;
  logic signed [39:0] sum_err_b;
  logic        [39:0] sum_abs_b;
  logic        [16:0] max_abs_b;
  logic        [31:0] err_cnt_b, smp_cnt_b;

  err_stat_accum #(.W_PROD(16), .N_SAMPLES(4), .ACC_W(40)) dut_a (
    .i_clk(clk), .i_rst(rst_a), .i_start(start_a), .i_valid(valid_a), .o_ready(ready_a),
    .i_exact(exact_a), .i_approx(approx_a), .o_sum_err(sum_err_a), .o_sum_abs_err(sum_abs_a),
    .o_max_exact(max_exact_a), .o_max_abs_err(max_abs_a), .o_err_cnt(err_cnt_a),
    .o_smp_cnt(smp_cnt_a), .o_done(done_a)
  );

  err_stat_accum #(.W_PROD(16), .N_SAMPLES(65536), .ACC_W(40)) dut_b (
    .i_clk(clk), .i_rst(rst_b), .i_start(start_b), .i_valid(valid_b), .o_ready(ready_b),
    .i_exact(exact_b), .i_approx(approx_b), .o_sum_err(sum_err_b), .o_sum_abs_err(sum_abs_b),
    .o_max_exact(max_exact_b), .o_max_abs_err(max_abs_b), .o_err_cnt(err_cnt_b),
    .o_smp_cnt(smp_cnt_b), .o_done(done_b)
  );

  int     n_assert = 0;
  int     n_fail   = 0;
  stats_t exp_q[$];
  int     sx[4];
  int     sa[4];

  task automatic check(input string tag, input longint obs, input longint exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic stats_t upd(input stats_t s, input int ex, input int ap);
    int diff;
    int ad;
    diff = ap - ex;
    ad   = (diff < 0) ? -diff : diff;
    s.sum_err += diff;
    s.sum_abs += ad;
    if (ex > s.max_exact) s.max_exact = ex;
    if (ad > s.max_abs) s.max_abs = ad;
    if (diff != 0) s.err_cnt++;
    s.smp_cnt++;
    return s;
  endfunction

  // Approximate radix-8 Booth product: the +-3 digit of the lowest group is
  // replaced by +-4, so no 3x multiple is needed there.
  function automatic int hlr_bm2(input int a, input int b);
    int prev;
    int mult;
    int d;
    prev = 0;
    mult = 0;
    for (int i = 0; i < 3; i++) begin
      d = -4 * ((b >> (3 * i + 2)) & 1) + 2 * ((b >> (3 * i + 1)) & 1)
          + ((b >> (3 * i)) & 1) + prev;
      prev = (b >> (3 * i + 2)) & 1;
      if (i == 0 && d == 3) d = 4;
      if (i == 0 && d == -3) d = -4;
      mult += d * (1 << (3 * i));
    end
    return a * mult;
  endfunction

  task automatic check_a(input string pfx, input stats_t e);
    check({pfx, "_sum_err"}, longint'(sum_err_a), e.sum_err);
    check({pfx, "_sum_abs"}, longint'(sum_abs_a), e.sum_abs);
    check({pfx, "_max_exact"}, longint'(max_exact_a), e.max_exact);
    check({pfx, "_max_abs"}, longint'(max_abs_a), e.max_abs);
    check({pfx, "_err_cnt"}, longint'(err_cnt_a), e.err_cnt);
    check({pfx, "_smp_cnt"}, longint'(smp_cnt_a), e.smp_cnt);
  endtask

  // One full short run of sx/sa; optional valid gaps and stray start pulses.
  task automatic run_a(input string pfx, input bit gaps, input bit start_mid);
    stats_t e;
    int     acc;
    int     budget;
    int     cyc;
    bit     phase;
    bit     take;
    e = '{default: 0};
    for (int i = 0; i < 4; i++) e = upd(e, sx[i], sa[i]);
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    check({pfx, "_ready_after_start"}, longint'(ready_a), 1);
    exp_q.push_back(e);
    acc    = 0;
    budget = 0;
    phase  = 1'b1;
    while (acc < 4 && budget < 64) begin
      valid_a  = gaps ? phase : 1'b1;
      phase    = ~phase;
      exact_a  = 16'(sx[acc]);
      approx_a = 16'(sa[acc]);
      start_a  = start_mid && (acc == 1);
      take     = valid_a && ready_a;
      @(negedge clk);
      budget++;
      if (take) acc++;
    end
    valid_a = 1'b0;
    start_a = start_mid;  // stray start while draining
    check({pfx, "_accepted"}, acc, 4);
    check({pfx, "_ready_in_drain"}, longint'(ready_a), 0);
    // Counting the last-accept cycle as cycle 1, o_done appears in cycle 4.
    cyc = 2;
    while (!done_a && cyc < 32) begin
      @(negedge clk);
      start_a = 1'b0;
      cyc++;
    end
    start_a = 1'b0;
    check({pfx, "_done_cycle"}, cyc, 4);
    e = exp_q.pop_front();
    check_a(pfx, e);
    repeat (3) @(negedge clk);
    check({pfx, "_hold_done"}, longint'(done_a), 1);
    check({pfx, "_hold_sum_abs"}, longint'(sum_abs_a), e.sum_abs);
    check({pfx, "_hold_sum_err"}, longint'(sum_err_a), e.sum_err);
  endtask

  task automatic sweep_b;
    stats_t e;
    int     ex;
    int     ap;
    int     guard;
    int     cyc;
    real    nmed_sw;
    real    nmed_dut;
    e = '{default: 0};
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    for (int a = -128; a < 128; a++) begin
      for (int b = -128; b < 128; b++) begin
        ex       = a * b;
        ap       = hlr_bm2(a, b);
        e        = upd(e, ex, ap);
        exact_b  = 16'(ex);
        approx_b = 16'(ap);
        valid_b  = 1'b1;
        guard    = 0;
        while (!ready_b && guard < 8) begin
          @(negedge clk);
          guard++;
        end
        @(negedge clk);
      end
    end
    valid_b = 1'b0;
    exp_q.push_back(e);
    check("sweep_ready_in_drain", longint'(ready_b), 0);
    cyc = 2;
    while (!done_b && cyc < 32) begin
      @(negedge clk);
      cyc++;
    end
    check("sweep_done_cycle", cyc, 4);
    e = exp_q.pop_front();
    check("sweep_smp_cnt", longint'(smp_cnt_b), 65536);
    check("sweep_sum_abs", longint'(sum_abs_b), e.sum_abs);
    check("sweep_sum_err", longint'(sum_err_b), e.sum_err);
    check("sweep_max_exact", longint'(max_exact_b), e.max_exact);
    check("sweep_max_abs", longint'(max_abs_b), e.max_abs);
    check("sweep_err_cnt", longint'(err_cnt_b), e.err_cnt);
    nmed_sw  = real'(e.sum_abs) / (65536.0 * real'(e.max_exact));
    nmed_dut = (max_exact_b == 16'sd0) ? -1.0
             : real'(longint'(sum_abs_b)) / (65536.0 * real'(longint'(max_exact_b)));
    n_assert++;
    assert ((nmed_dut - nmed_sw) < 1.0e-12 && (nmed_sw - nmed_dut) < 1.0e-12) else begin
      n_fail++;
      $error("FAIL sweep_nmed: observed %g expected %g", nmed_dut, nmed_sw);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1; start_a = 1'b0; valid_a = 1'b0; exact_a = '0; approx_a = '0;
    rst_b = 1'b1; start_b = 1'b0; valid_b = 1'b0; exact_b = '0; approx_b = '0;
    #12;
    // Reset state
    check("rst_ready", longint'(ready_a), 0);
    check("rst_done", longint'(done_a), 0);
    check("rst_smp_cnt", longint'(smp_cnt_a), 0);
    check("rst_sum_abs", longint'(sum_abs_a), 0);
    @(negedge clk); rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    check("idle_ready", longint'(ready_a), 0);

    // Basic run
    sx = '{100, 50, -20, 7};
    sa = '{100, 48, -17, 7};
    run_a("basic", 1'b0, 1'b0);

    // Same data with valid toggling every cycle
    run_a("gaps", 1'b1, 1'b0);

    // Extreme operands: difference needs the extra bit
    sx = '{-32768, 0, 0, 0};
    sa = '{32767, 0, 0, 0};
    run_a("extreme", 1'b0, 1'b0);

    // Reset after two accepts discards the run
    sx = '{100, 50, -20, 7};
    sa = '{100, 48, -17, 7};
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    valid_a = 1'b1; exact_a = 16'(sx[0]); approx_a = 16'(sa[0]);
    @(negedge clk);
    exact_a = 16'(sx[1]); approx_a = 16'(sa[1]);
    @(negedge clk);
    valid_a = 1'b0;
    check("pre_rst_smp_cnt", longint'(smp_cnt_a), 2);
    rst_a = 1'b1;
    #1;
    check("midrst_smp_cnt", longint'(smp_cnt_a), 0);
    check("midrst_max_exact", longint'(max_exact_a), 0);
    check("midrst_sum_err", longint'(sum_err_a), 0);
    check("midrst_ready", longint'(ready_a), 0);
    check("midrst_state", longint'(dut_a.state_q), longint'(StIdle));
    @(negedge clk); rst_a = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("postrst_ready", longint'(ready_a), 0);
    end
    check("postrst_sum_abs", longint'(sum_abs_a), 0);
    check("postrst_err_cnt", longint'(err_cnt_a), 0);
    run_a("after_rst", 1'b0, 1'b0);

    // Start pulses in RUN and DRAIN are ignored
    run_a("start_ignored", 1'b0, 1'b1);

    // Start in DONE clears everything and re-opens the input
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    check("restart_ready", longint'(ready_a), 1);
    check("restart_done", longint'(done_a), 0);
    check("restart_sum_abs", longint'(sum_abs_a), 0);
    check("restart_max_exact", longint'(max_exact_a), 0);
    check("restart_smp_cnt", longint'(smp_cnt_a), 0);

    // Full signed-operand sweep
    sweep_b();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
